// File: rtl/ebus_diag_reader_pkg.sv
// ============================================================================
// Module      : ebus_diag_reader_pkg
// Description : Shared select codes, diagnostic function prefix, controller
//               state encoding and select-wrap helper for the EBUS
//               diagnostic reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ebus_diag_reader_pkg;

    // EBUS diagnostic source select codes
    localparam logic [2:0] SEL_AR  = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_MQ  = 3'd2;
    localparam logic [2:0] SEL_FM  = 3'd3;
    localparam logic [2:0] SEL_BRX = 3'd4;
    localparam logic [2:0] SEL_ARX = 3'd5;
    localparam logic [2:0] SEL_ADX = 3'd6;
    localparam logic [2:0] SEL_AD  = 3'd7;

    // Upper six bits of the diagnostic function code (octal 12)
    localparam logic [5:0] FUNC_PREFIX = 6'o12;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Next source in a scan; AD wraps back to AR
    function automatic logic [2:0] next_sel(input logic [2:0] s);
        case (s)
            SEL_AR:  next_sel = SEL_BR;
            SEL_BR:  next_sel = SEL_MQ;
            SEL_MQ:  next_sel = SEL_FM;
            SEL_FM:  next_sel = SEL_BRX;
            SEL_BRX: next_sel = SEL_ARX;
            SEL_ARX: next_sel = SEL_ADX;
            SEL_ADX: next_sel = SEL_AD;
            SEL_AD:  next_sel = SEL_AR;
            default: next_sel = SEL_AR;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ebus_diag_timer.sv
// ============================================================================
// Module      : ebus_diag_timer
// Description : Loadable down-counter shared by the settle and timeout
//               phases. last_o flags the final counted cycle (count == 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ebus_diag_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load takes priority over decrement; the count saturates at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/ebus_diag_reader.sv
// ============================================================================
// Module      : ebus_diag_reader
// Description : Reads one or all eight EBUS diagnostic sources. Issues the
//               octal-12X diagnostic read strobe, waits for the EDP to drive
//               EBUS (with timeout), lets the bus settle, captures the word
//               and returns it through a valid/ready response channel.
//               Optional feature macro: EBUS_DIAG_PARITY_EN adds an
//               odd-parity output registered with the captured word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ebus_diag_reader
    import ebus_diag_reader_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [0:2]  reqSel,
    input  logic        reqScan,
    output logic [0:8]  diagFunc,
    output logic        diagReadFunc12X,
    input  logic        EDPdrivingEBUS,
    input  logic [0:35] EBUS,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [0:35] rspData,
    output logic [0:2]  rspSel,
    output logic        rspTimeout,
    output logic        rspLast
`ifdef EBUS_DIAG_PARITY_EN
    ,
    output logic        rspParity
`endif
);

    localparam int         TMR_W      = 8;
    localparam logic [7:0] SETTLE_VAL = TMR_W'(SETTLE_CYCLES);
    localparam logic [7:0] TMO_VAL    = TMR_W'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [0:2]  sel_q, sel_d;
    logic        scan_q, scan_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [0:35] data_q, data_d;
    logic        tmo_q, tmo_d;
`ifdef EBUS_DIAG_PARITY_EN
    logic        par_q, par_d;
`endif

    logic        tmr_load;
    logic [7:0]  tmr_val;
    logic        tmr_dec;
    logic        tmr_last;
    logic        last_word;

    // Word is final for a single read, the eighth word of a scan, or an abort
    assign last_word = !scan_q || (wcnt_q == 3'd7) || tmo_q;

    ebus_diag_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .last_o     (tmr_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, timer control and response datapath next values
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        scan_d   = scan_q;
        wcnt_d   = wcnt_q;
        data_d   = data_q;
        tmo_d    = tmo_q;
`ifdef EBUS_DIAG_PARITY_EN
        par_d    = par_q;
`endif
        tmr_load = 1'b0;
        tmr_val  = TMO_VAL;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    sel_d    = reqSel;
                    scan_d   = reqScan;
                    wcnt_d   = 3'd0;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_VAL;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (EDPdrivingEBUS) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_VAL;
                    state_d  = ST_SETTLE;
                end else if (tmr_last) begin
                    data_d   = '0;
                    tmo_d    = 1'b1;
`ifdef EBUS_DIAG_PARITY_EN
                    par_d    = 1'b1;
`endif
                    state_d  = ST_RESP;
                end else begin
                    tmr_dec  = 1'b1;
                end
            end
            ST_SETTLE: begin
                // A dropped drive restarts the whole wait from scratch
                if (!EDPdrivingEBUS) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMO_VAL;
                    state_d  = ST_DRIVE;
                end else if (tmr_last) begin
                    data_d   = EBUS;
                    tmo_d    = 1'b0;
`ifdef EBUS_DIAG_PARITY_EN
                    par_d    = ~^EBUS;
`endif
                    state_d  = ST_RESP;
                end else begin
                    tmr_dec  = 1'b1;
                end
            end
            ST_RESP: begin
                if (rspReady) begin
                    if (last_word) begin
                        state_d  = ST_IDLE;
                    end else begin
                        sel_d    = next_sel(sel_q);
                        wcnt_d   = wcnt_q + 3'd1;
                        tmr_load = 1'b1;
                        tmr_val  = TMO_VAL;
                        state_d  = ST_DRIVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request/response datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= '0;
            scan_q <= 1'b0;
            wcnt_q <= '0;
            data_q <= '0;
            tmo_q  <= 1'b0;
`ifdef EBUS_DIAG_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            sel_q  <= sel_d;
            scan_q <= scan_d;
            wcnt_q <= wcnt_d;
            data_q <= data_d;
            tmo_q  <= tmo_d;
`ifdef EBUS_DIAG_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    // Outputs decoded from state and the response registers
    always_comb begin
        reqReady        = (state_q == ST_IDLE);
        diagReadFunc12X = (state_q == ST_DRIVE) || (state_q == ST_SETTLE);
        diagFunc        = diagReadFunc12X ? {FUNC_PREFIX, sel_q} : 9'd0;
        rspValid        = (state_q == ST_RESP);
        rspLast         = (state_q == ST_RESP) && last_word;
        rspData         = data_q;
        rspSel          = sel_q;
        rspTimeout      = tmo_q;
    end

`ifdef EBUS_DIAG_PARITY_EN
    assign rspParity = par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ebus_diag_reader.sv
// ============================================================================
// Module      : tb_ebus_diag_reader
// Description : Self-checking bench for ebus_diag_reader: table of single
//               reads plus directed scan, backpressure, settle-drop and
//               reset-in-response sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ebus_diag_reader;

    localparam int S = 2;
    localparam int T = 15;
    localparam int NEVER = 1000;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [0:2]  reqSel;
    logic        reqScan;
    logic [0:8]  diagFunc;
    logic        diagReadFunc12X;
    logic        EDPdrivingEBUS;
    logic [0:35] EBUS;
    logic        rspValid;
    logic        rspReady;
    logic [0:35] rspData;
    logic [0:2]  rspSel;
    logic        rspTimeout;
    logic        rspLast;
`ifdef EBUS_DIAG_PARITY_EN
    logic        rspParity;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    ebus_diag_reader #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reqValid        (reqValid),
        .reqReady        (reqReady),
        .reqSel          (reqSel),
        .reqScan         (reqScan),
        .diagFunc        (diagFunc),
        .diagReadFunc12X (diagReadFunc12X),
        .EDPdrivingEBUS  (EDPdrivingEBUS),
        .EBUS            (EBUS),
        .rspValid        (rspValid),
        .rspReady        (rspReady),
        .rspData         (rspData),
        .rspSel          (rspSel),
        .rspTimeout      (rspTimeout),
        .rspLast         (rspLast)
`ifdef EBUS_DIAG_PARITY_EN
        ,
        .rspParity       (rspParity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    task automatic accept(input logic [2:0] sel, input logic scan);
        check("req_ready_pre", reqReady, 1'b1);
        reqValid = 1'b1;
        reqSel   = sel;
        reqScan  = scan;
        tick();
        reqValid = 1'b0;
        reqScan  = 1'b0;
    endtask

    // EDP model: drives EBUS once more than 'lat' strobe cycles have been seen
    task automatic wait_resp(input int lat, input logic [35:0] val, output int cyc, output int strobes);
        cyc     = 0;
        strobes = 0;
        while (!rspValid && cyc < 100) begin
            if (diagReadFunc12X) strobes++;
            EDPdrivingEBUS = diagReadFunc12X && (strobes > lat);
            EBUS           = EDPdrivingEBUS ? val : ~val;
            tick();
            cyc++;
        end
        EDPdrivingEBUS = 1'b0;
        EBUS           = 36'o707070707070;
        if (!rspValid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_wait: got no response, expected one within 100 cycles");
        end
    endtask

    task automatic handshake();
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic        scan;
        int          lat;
        logic [35:0] val;
        int          exp_cyc;
        int          exp_str;
        logic [35:0] exp_data;
        logic        exp_to;
        logic [8:0]  exp_func;
        logic        exp_par;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          cyc;
        int          str;
        int          seen;
        logic [35:0] v;
        int          exp_sel[8];

        tbl[0] = '{3'd3, 1'b0, 1,     36'o123456701234, 4,  4,  36'o123456701234, 1'b0, 9'o123, 1'b0};
        tbl[1] = '{3'd0, 1'b0, 0,     36'o777777777777, 3,  3,  36'o777777777777, 1'b0, 9'o120, 1'b1};
        tbl[2] = '{3'd7, 1'b0, 5,     36'o000000000001, 8,  8,  36'o000000000001, 1'b0, 9'o127, 1'b0};
        tbl[3] = '{3'd5, 1'b1, NEVER, 36'o000000000555, 15, 15, 36'o0,            1'b1, 9'o125, 1'b1};
        tbl[4] = '{3'd2, 1'b0, 14,    36'o246013570246, 17, 17, 36'o246013570246, 1'b0, 9'o122, 1'b1};
        tbl[5] = '{3'd1, 1'b0, 2,     36'o000000000000, 5,  5,  36'o0,            1'b0, 9'o121, 1'b1};
        exp_sel = '{6, 7, 0, 1, 2, 3, 4, 5};

        reset          = 1'b1;
        reqValid       = 1'b0;
        reqSel         = 3'd0;
        reqScan        = 1'b0;
        EDPdrivingEBUS = 1'b0;
        EBUS           = 36'o0;
        rspReady       = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_reqReady", reqReady, 1'b1);
        check("rst_rspValid", rspValid, 1'b0);
        check("rst_strobe",   diagReadFunc12X, 1'b0);
        check("rst_diagFunc", diagFunc, 9'd0);
        check("rst_rspData",  rspData, 36'o0);
        check("rst_rspSel",   rspSel, 3'd0);
        check("rst_rspTmo",   rspTimeout, 1'b0);
        check("rst_rspLast",  rspLast, 1'b0);
`ifdef EBUS_DIAG_PARITY_EN
        check("rst_parity",   rspParity, 1'b0);
`endif

        // Table of single reads (a timeout ends the request even with scan set)
        for (int i = 0; i < 6; i++) begin
            accept(tbl[i].sel, tbl[i].scan);
            check("tbl_strobe",   diagReadFunc12X, 1'b1);
            check("tbl_diagFunc", diagFunc, tbl[i].exp_func);
            check("tbl_reqReady_busy", reqReady, 1'b0);
            wait_resp(tbl[i].lat, tbl[i].val, cyc, str);
            check("tbl_latency",  36'(cyc), 36'(tbl[i].exp_cyc));
            check("tbl_strobes",  36'(str), 36'(tbl[i].exp_str));
            check("tbl_data",     rspData, tbl[i].exp_data);
            check("tbl_sel",      rspSel, tbl[i].sel);
            check("tbl_timeout",  rspTimeout, tbl[i].exp_to);
            check("tbl_last",     rspLast, 1'b1);
            check("tbl_rsp_func", diagFunc, 9'd0);
`ifdef EBUS_DIAG_PARITY_EN
            check("tbl_parity",   rspParity, tbl[i].exp_par);
`endif
            handshake();
            check("tbl_idle_ready", reqReady, 1'b1);
            check("tbl_idle_valid", rspValid, 1'b0);
        end

        // Scan from ADX wrapping through AR
        accept(3'd6, 1'b1);
        for (int k = 0; k < 8; k++) begin
            v = 36'o100000000000 + 36'(k);
            wait_resp(1, v, cyc, str);
            check("scan_latency", 36'(cyc), 36'd4);
            check("scan_sel",     rspSel, 36'(exp_sel[k]));
            check("scan_data",    rspData, v);
            check("scan_last",    rspLast, (k == 7) ? 1'b1 : 1'b0);
            check("scan_timeout", rspTimeout, 1'b0);
            handshake();
            if (k < 7) begin
                check("scan_no_gap",   diagReadFunc12X, 1'b1);
                check("scan_nextfunc", diagFunc, {6'o12, 3'(exp_sel[k + 1])});
            end else begin
                check("scan_end_ready", reqReady, 1'b1);
            end
        end

        // Backpressure: response fields hold while rspReady stays low
        accept(3'd4, 1'b0);
        wait_resp(0, 36'o314157265350, cyc, str);
        for (int k = 0; k < 10; k++) begin
            EBUS           = 36'({$urandom(), $urandom()});
            EDPdrivingEBUS = $urandom_range(0, 1) == 1;
            tick();
            check("bp_data", rspData, 36'o314157265350);
            check("bp_ctl",  {rspValid, rspSel, rspTimeout, rspLast}, 6'b1_100_0_1);
        end
        EDPdrivingEBUS = 1'b0;
        handshake();
        check("bp_done_ready", reqReady, 1'b1);

        // Drive drop during settle restarts the wait; post-restart value captured
        accept(3'd1, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        EDPdrivingEBUS = 1'b1;
        EBUS           = 36'o111111111111;
        tick();
        EDPdrivingEBUS = 1'b0;
        tick();
        check("drop_back_drive", diagReadFunc12X, 1'b1);
        for (int k = 0; k < 14; k++) tick();
        check("drop_restarted", rspValid, 1'b0);
        EDPdrivingEBUS = 1'b1;
        EBUS           = 36'o222222222222;
        tick();
        tick();
        check("drop_settling", rspValid, 1'b0);
        tick();
        EDPdrivingEBUS = 1'b0;
        EBUS           = 36'o333333333333;
        check("drop_valid",   rspValid, 1'b1);
        check("drop_data",    rspData, 36'o222222222222);
        check("drop_timeout", rspTimeout, 1'b0);
        handshake();

        // Reset while holding a mid-scan response
        accept(3'd0, 1'b1);
        wait_resp(1, 36'o4444, cyc, str);
        handshake();
        wait_resp(1, 36'o5555, cyc, str);
        check("rr_sel", rspSel, 3'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_ready", reqReady, 1'b1);
        check("rr_valid", rspValid, 1'b0);
        check("rr_data",  rspData, 36'o0);
        seen = 0;
        EDPdrivingEBUS = 1'b1;
        rspReady       = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (rspValid || diagReadFunc12X) seen++;
        end
        EDPdrivingEBUS = 1'b0;
        rspReady       = 1'b0;
        check("rr_no_activity", 36'(seen), 36'd0);
        check("rr_ready_later", reqReady, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
